// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversamples SCL/SDA on pclk, detects START/STOP, matches
// its 7-bit address, shifts in data bytes, ACKs them and hands them to a one-entry holding register.
module i2c_slave_rx #(
   parameter logic [6:0] SLV_ADDR = 7'h2A
) (
   input  logic       pclk,
   input  logic       prst,
   input  logic       i_scl_in,
   input  logic       i_sda_in,
   output logic       o_sda_oe,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   input  logic       i_rx_taken,
   output logic       o_addr_match,
   output logic       o_busy,
   output logic       o_start_det,
   output logic       o_stop_det,
   output logic       o_overflow,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      DATA     = 3'd3,
      DATA_ACK = 3'd4,
      IGNORE   = 3'd5
   } state_t;

   state_t     state;
   logic       scl_m, scl_s, scl_d;
   logic       sda_m, sda_s, sda_d;
   logic [7:0] shift;
   logic [3:0] bit_cnt;

   logic scl_rise, scl_fall, start_ev, stop_ev, space;

   // SDA may only move as START/STOP while SCL is stably high on both samples.
   assign scl_rise = scl_s & ~scl_d;
   assign scl_fall = ~scl_s & scl_d;
   assign start_ev = ~sda_s & sda_d & scl_s & scl_d;
   assign stop_ev  = sda_s & ~sda_d & scl_s & scl_d;
   assign space    = ~o_rx_valid | i_rx_taken;

   assign dbg_state = state;

   always_ff @(posedge pclk) begin
      if (prst) begin
         state        <= IDLE;
         scl_m        <= 1'b1;
         scl_s        <= 1'b1;
         scl_d        <= 1'b1;
         sda_m        <= 1'b1;
         sda_s        <= 1'b1;
         sda_d        <= 1'b1;
         shift        <= 8'h00;
         bit_cnt      <= 4'd0;
         o_sda_oe     <= 1'b0;
         o_rx_data    <= 8'h00;
         o_rx_valid   <= 1'b0;
         o_addr_match <= 1'b0;
         o_busy       <= 1'b0;
         o_start_det  <= 1'b0;
         o_stop_det   <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         scl_m       <= i_scl_in;
         scl_s       <= scl_m;
         scl_d       <= scl_s;
         sda_m       <= i_sda_in;
         sda_s       <= sda_m;
         sda_d       <= sda_s;
         o_start_det <= 1'b0;
         o_stop_det  <= 1'b0;
         o_overflow  <= 1'b0;

         // A load later in this block overrides this clear.
         if (i_rx_taken)
            o_rx_valid <= 1'b0;

         if (start_ev) begin
            state        <= ADDR;
            bit_cnt      <= 4'd0;
            o_sda_oe     <= 1'b0;
            o_addr_match <= 1'b0;
            o_start_det  <= 1'b1;
            o_busy       <= 1'b1;
         end else if (stop_ev) begin
            state        <= IDLE;
            o_sda_oe     <= 1'b0;
            o_addr_match <= 1'b0;
            o_stop_det   <= 1'b1;
            o_busy       <= 1'b0;
         end else begin
            case (state)
               ADDR, DATA: begin
                  if (scl_rise) begin
                     shift   <= {shift[6:0], sda_s};
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall && bit_cnt == 4'd8) begin
                     if (state == ADDR) begin
                        if (shift[7:1] == SLV_ADDR && !shift[0]) begin
                           o_sda_oe     <= 1'b1;
                           o_addr_match <= 1'b1;
                           state        <= ADDR_ACK;
                        end else begin
                           o_sda_oe <= 1'b0;
                           state    <= IGNORE;
                        end
                     end else begin
                        if (space) begin
                           o_rx_data  <= shift;
                           o_rx_valid <= 1'b1;
                           o_sda_oe   <= 1'b1;
                        end else begin
                           o_overflow <= 1'b1;
                        end
                        state <= DATA_ACK;
                     end
                  end
               end
               ADDR_ACK, DATA_ACK: begin
                  if (scl_fall) begin
                     o_sda_oe <= 1'b0;
                     bit_cnt  <= 4'd0;
                     state    <= DATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
